// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: command-side burst controller for the 8x8 register-file memory.
// Accepts single/burst read and write commands over valid/ready, streams write
// beats into the memory and read beats out with backpressure, one memory access
// per beat, with the address auto-incrementing and wrapping at the memory depth.
module mem_burst_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [DATA_W-1:0] wdat_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              cmd_done,
  output logic              mem_enable,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  // Encodings are fixed so the state register keeps its legacy bit values.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAP   = 3'd3,
    RD_RSP   = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] beats_left;

  // Burst sequencing: latch the command, walk addresses, count beats, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      rsp_data   <= '0;
      cmd_done   <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr   <= cmd_addr;
            beats_left <= cmd_len;
            state      <= cmd_write ? WR : RD_ISSUE;
          end
        end
        WR: begin
          if (wdat_valid) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (beats_left == '0) begin
              cmd_done <= 1'b1;
              state    <= IDLE;
            end else begin
              beats_left <= beats_left - ADDR_W'(1);
            end
          end
        end
        RD_ISSUE: state <= RD_CAP;
        RD_CAP: begin
          rsp_data <= mem_rd_data;
          state    <= RD_RSP;
        end
        RD_RSP: begin
          if (rsp_ready) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (beats_left == '0) begin
              cmd_done <= 1'b1;
              state    <= IDLE;
            end else begin
              beats_left <= beats_left - ADDR_W'(1);
              state      <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and memory control pins decoded from the current state.
  always_comb begin
    cmd_ready   = 1'b0;
    wdat_ready  = 1'b0;
    rsp_valid   = 1'b0;
    mem_enable  = 1'b0;
    mem_rd_wr   = 1'b1;
    mem_addr    = cur_addr;
    mem_wr_data = '0;
    case (state)
      IDLE:     cmd_ready = 1'b1;
      WR: begin
        wdat_ready  = 1'b1;
        mem_enable  = wdat_valid;
        mem_rd_wr   = 1'b0;
        mem_wr_data = wdat_data;
      end
      RD_ISSUE: mem_enable = 1'b1;
      RD_RSP:   rsp_valid  = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural 8x8 register-file memory.
module tb_mem_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr, cmd_len;
  logic       wdat_valid, wdat_ready;
  logic [7:0] wdat_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       cmd_done;
  logic       mem_enable, mem_rd_wr;
  logic [2:0] mem_addr;
  logic [7:0] mem_wr_data, mem_rd_data;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;

  logic [7:0] tb_mem [8];

  always #5 clk = ~clk;

  mem_burst_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cmd_done(cmd_done),
    .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // Register-file memory: one-cycle registered read, contents reset to 0xFF.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) tb_mem[i] <= 8'hFF;
      mem_rd_data <= 8'h00;
    end else if (mem_enable) begin
      if (mem_rd_wr) mem_rd_data <= tb_mem[mem_addr];
      else           tb_mem[mem_addr] <= mem_wr_data;
    end
  end

  // Count memory accesses seen at clock edges.
  always @(posedge clk) begin
    if (mem_enable) en_cnt <= en_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [2:0] a, input logic [2:0] l);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [2:0] l,
                          input logic [7:0] d [8], output logic done_seen);
    issue_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      wdat_valid = 1'b1; wdat_data = d[i];
      step();
    end
    wdat_valid = 1'b0;
    done_seen = cmd_done;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [2:0] l,
                         output logic [7:0] q [8], output logic ok);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) q[i] = 8'hxx;
    issue_cmd(1'b0, a, l);
    rsp_ready = 1'b1;
    for (int i = 0; i <= int'(l); i++) begin
      for (int n = 0; n < 10 && !rsp_valid; n++) step();
      if (!rsp_valid) begin
        ok = 1'b0;
        break;
      end
      q[i] = rsp_data;
      step();
    end
    rsp_ready = 1'b0;
    if (!cmd_done) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    total++; if (mem_enable !== 1'b0) begin bad++; $display("FAIL reset_mem_enable: got %b want 0", mem_enable); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (cmd_done !== 1'b0) begin bad++; $display("FAIL reset_cmd_done: got %b want 0", cmd_done); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    total++; if (wdat_ready !== 1'b0) begin bad++; $display("FAIL reset_wdat_ready: got %b want 0", wdat_ready); end
    total++; if (mem_rd_wr !== 1'b1) begin bad++; $display("FAIL reset_mem_rd_wr: got %b want 1", mem_rd_wr); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    issue_cmd(1'b0, 3'd3, 3'd0);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL sr_cmd_ready_busy: got %b want 0", cmd_ready); end
    total++; if ({mem_enable, mem_rd_wr, mem_addr} !== {1'b1, 1'b1, 3'd3}) begin
      bad++; $display("FAIL sr_issue: got en=%b rw=%b addr=%0d want en=1 rw=1 addr=3", mem_enable, mem_rd_wr, mem_addr); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL sr_valid_c1: got %b want 0", rsp_valid); end
    step();
    total++; if ({rsp_valid, mem_enable} !== 2'b00) begin bad++; $display("FAIL sr_cap: got valid=%b en=%b want 0 0", rsp_valid, mem_enable); end
    step();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL sr_valid_c3: got %b want 1", rsp_valid); end
    total++; if (rsp_data !== 8'hFF) begin bad++; $display("FAIL sr_data: got %h want ff", rsp_data); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++; if ({cmd_done, cmd_ready, rsp_valid} !== 3'b110) begin
      bad++; $display("FAIL sr_done: got done=%b ready=%b valid=%b want 1 1 0", cmd_done, cmd_ready, rsp_valid); end
    step();
    total++; if (cmd_done !== 1'b0) begin bad++; $display("FAIL sr_done_pulse: got %b want 0", cmd_done); end
  endtask

  task automatic test_wrap();
    logic [7:0] d [8];
    logic [7:0] q [8];
    logic ok;
    d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
    do_write(3'd6, 3'd3, d, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_wr_done: got %b want 1", ok); end
    total++; if ({tb_mem[6], tb_mem[7], tb_mem[0], tb_mem[1], tb_mem[2]} !== 40'hA0A1A2A3FF) begin
      bad++; $display("FAIL wrap_mem: got %h %h %h %h %h want a0 a1 a2 a3 ff",
                      tb_mem[6], tb_mem[7], tb_mem[0], tb_mem[1], tb_mem[2]); end
    do_read(3'd6, 3'd3, q, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_rd_ok: got %b want 1", ok); end
    for (int i = 0; i < 4; i++) begin
      total++; if (q[i] !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL wrap_rd_beat%0d: got %h want %h", i, q[i], 8'hA0 + 8'(i)); end
    end
    do_read(3'd2, 3'd0, q, ok);
    total++; if ({ok, q[0]} !== {1'b1, 8'hFF}) begin bad++; $display("FAIL wrap_addr2: got ok=%b %h want 1 ff", ok, q[0]); end
  endtask

  task automatic test_write_stall();
    logic v [7];
    int beat;
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    beat = 0;
    issue_cmd(1'b1, 3'd4, 3'd3);
    for (int k = 0; k < 7; k++) begin
      wdat_valid = v[k]; wdat_data = 8'hB0 + 8'(beat);
      #1;
      total++; if ({wdat_ready, mem_enable, mem_rd_wr} !== {1'b1, v[k], 1'b0}) begin
        bad++; $display("FAIL ws_ctl%0d: got rdy=%b en=%b rw=%b want 1 %b 0", k, wdat_ready, mem_enable, mem_rd_wr, v[k]); end
      if (v[k]) begin
        total++; if ({mem_addr, mem_wr_data} !== {3'(4 + beat), 8'hB0 + 8'(beat)}) begin
          bad++; $display("FAIL ws_addr%0d: got addr=%0d data=%h want %0d %h", k, mem_addr, mem_wr_data, 3'(4 + beat), 8'hB0 + 8'(beat)); end
        beat++;
      end
      step();
      total++; if (cmd_done !== (k == 6)) begin bad++; $display("FAIL ws_done%0d: got %b want %b", k, cmd_done, k == 6); end
    end
    wdat_valid = 1'b0;
    total++; if ({tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]} !== 32'hB0B1B2B3) begin
      bad++; $display("FAIL ws_mem: got %h %h %h %h want b0 b1 b2 b3", tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]); end
  endtask

  task automatic test_read_stall();
    logic [7:0] d [8];
    logic ok;
    int en0;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) d[i] = 8'hC0 + 8'(i);
    do_write(3'd0, 3'd7, d, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rs_fill_done: got %b want 1", ok); end
    en0 = en_cnt;
    issue_cmd(1'b0, 3'd5, 3'd7);
    for (int i = 0; i < 8; i++) begin
      exp = 8'hC0 + 8'((5 + i) % 8);
      rsp_ready = (i != 2);
      for (int n = 0; n < 10 && !rsp_valid; n++) step();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rs_timeout%0d: got valid=%b want 1", i, rsp_valid); break; end
      total++; if (rsp_data !== exp) begin bad++; $display("FAIL rs_beat%0d: got %h want %h", i, rsp_data, exp); end
      if (i == 2) begin
        for (int s = 0; s < 5; s++) begin
          step();
          total++; if ({rsp_valid, rsp_data, mem_enable} !== {1'b1, exp, 1'b0}) begin
            bad++; $display("FAIL rs_stall%0d: got valid=%b data=%h en=%b want 1 %h 0", s, rsp_valid, rsp_data, mem_enable, exp); end
        end
        rsp_ready = 1'b1;
      end
      step();
    end
    rsp_ready = 1'b0;
    total++; if (cmd_done !== 1'b1) begin bad++; $display("FAIL rs_done: got %b want 1", cmd_done); end
    total++; if (en_cnt - en0 !== 8) begin bad++; $display("FAIL rs_en_count: got %0d want 8", en_cnt - en0); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] q [8];
    logic ok;
    int dones;
    issue_cmd(1'b1, 3'd0, 3'd3);
    wdat_valid = 1'b1; wdat_data = 8'hE0; step();
    wdat_data = 8'hE1; step();
    wdat_data = 8'hE2;
    #2; rst = 1'b1; #1;
    total++; if ({mem_enable, wdat_ready, cmd_done, rsp_valid} !== 4'b0000) begin
      bad++; $display("FAIL rm_drop: got en=%b wrdy=%b done=%b valid=%b want 0 0 0 0", mem_enable, wdat_ready, cmd_done, rsp_valid); end
    wdat_valid = 1'b0;
    step();
    rst = 1'b0;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_cmd_ready: got %b want 1", cmd_ready); end
    dones = 0;
    for (int s = 0; s < 4; s++) begin step(); if (cmd_done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL rm_no_done: got %0d pulses want 0", dones); end
    do_read(3'd0, 3'd7, q, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rm_rd_ok: got %b want 1", ok); end
    for (int i = 0; i < 8; i++) begin
      total++; if (q[i] !== 8'hFF) begin bad++; $display("FAIL rm_readback%0d: got %h want ff", i, q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_len = 3'd1;
    step();
    cmd_write = 1'b0;
    wdat_valid = 1'b1; wdat_data = 8'hD0; step();
    wdat_data = 8'hD1; step();
    wdat_valid = 1'b0;
    total++; if ({cmd_done, cmd_ready} !== 2'b11) begin bad++; $display("FAIL b2b_done_ready: got done=%b ready=%b want 1 1", cmd_done, cmd_ready); end
    step();
    cmd_valid = 1'b0;
    total++; if ({cmd_ready, mem_enable, mem_rd_wr, mem_addr} !== {1'b0, 1'b1, 1'b1, 3'd2}) begin
      bad++; $display("FAIL b2b_accept: got rdy=%b en=%b rw=%b addr=%0d want 0 1 1 2", cmd_ready, mem_enable, mem_rd_wr, mem_addr); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 10 && !rsp_valid; n++) step();
      total++; if ({rsp_valid, rsp_data} !== {1'b1, 8'hD0 + 8'(i)}) begin
        bad++; $display("FAIL b2b_beat%0d: got valid=%b data=%h want 1 %h", i, rsp_valid, rsp_data, 8'hD0 + 8'(i)); end
      step();
    end
    rsp_ready = 1'b0;
    total++; if (cmd_done !== 1'b1) begin bad++; $display("FAIL b2b_rd_done: got %b want 1", cmd_done); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdat_valid = 1'b0; wdat_data = '0; rsp_ready = 1'b0;
    test_reset();
    test_single_read();
    test_wrap();
    test_write_stall();
    test_read_stall();
    test_reset_mid_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Command-side controller that sits directly upstream of the team's 8x8 register-file memory (enable / rd_wr / addr / wr_data in, registered rd_data out, one-cycle read latency, contents reset to 0xFF). It accepts single or burst read/write commands over a valid/ready handshake. It streams write data in and read data out with backpressure, and sequences the memory's control pins one beat at a time. Addresses auto-increment and wrap modulo the memory depth.

Parameters:
ADDR_W, 3, memory address width; depth = 2**ADDR_W; also the width of cmd_len.
DATA_W, 8, data width of the memory and of the data streams.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command (high only in IDLE).
cmd_write  input  1  1 = write burst, 0 = read burst.
cmd_addr  input  ADDR_W  start address.
cmd_len  input  ADDR_W  beats minus one (0 = 1 beat, 7 = 8 beats).
wdat_valid  input  1  write beat present.
wdat_ready  output  1  write beat accepted this cycle.
wdat_data  input  DATA_W  write beat data.
rsp_valid  output  1  read beat present.
rsp_ready  input  1  consumer takes read beat.
rsp_data  output  DATA_W  read beat data.
cmd_done  output  1  one-cycle pulse when the last beat of a burst completes.
mem_enable  output  1  to memory enable.
mem_rd_wr  output  1  to memory rd_wr (1 = read, 0 = write).
mem_addr  output  ADDR_W  to memory addr.
mem_wr_data  output  DATA_W  to memory wr_data.
mem_rd_data  input  DATA_W  from memory rd_data.

Behaviour:
- Reset (async, any state): state=IDLE; cur_addr=0; beats_left=0; rsp_data=0; cmd_done=0. mem_enable=0 and rsp_valid=0 immediately. mem_rd_wr idles at 1. An in-flight burst is abandoned with no cmd_done and no further memory access. The memory itself resets to 0xFF.
- Handshakes: a transfer occurs on a rising edge with valid&&ready. valid must not depend on ready. rsp_valid/rsp_data hold stable until accepted.
- States: IDLE, WR, RD_ISSUE, RD_CAP, RD_RSP.
- IDLE: cmd_ready=1, mem_enable=0. On cmd_valid: latch cur_addr=cmd_addr and beats_left=cmd_len, then go to WR if cmd_write, else RD_ISSUE.
- WR (combinational outputs):
  - wdat_ready=1; mem_enable=wdat_valid; mem_rd_wr=0; mem_addr=cur_addr; mem_wr_data=wdat_data.
  - On each accepted beat, cur_addr += 1 (wraps 7->0). If beats_left==0, pulse cmd_done next cycle and go to IDLE; else beats_left -= 1.
  - wdat_valid low stalls with no memory access.
- RD_ISSUE: mem_enable=1, mem_rd_wr=1, mem_addr=cur_addr; always advances to RD_CAP after 1 cycle.
- RD_CAP: mem_enable=0; rsp_data <= mem_rd_data; go to RD_RSP.
- RD_RSP: rsp_valid=1, mem_enable=0.
  - On rsp_ready: cur_addr += 1 (wrap).
  - If beats_left==0, pulse cmd_done and go to IDLE; else beats_left -= 1 and go to RD_ISSUE.
- Read latency: command accepted at edge N -> rsp_valid high in cycle N+3. Back-to-back beats take 3 cycles each with rsp_ready held high.
- Write throughput: 1 beat/cycle with wdat_valid held high.
- cmd_done asserts in the cycle after the final beat's handshake edge, for exactly 1 cycle, concurrently with cmd_ready=1. A new command may be accepted in that same cycle.
- Address wrap applies to both directions. A burst of len 7 touches all 8 locations exactly once.
- mem_enable is never asserted outside WR (with wdat_valid) and RD_ISSUE. There is no simultaneous read and write.
- wdat_valid in non-WR states is ignored; wdat_ready=0 there. rsp_ready outside RD_RSP is ignored.

Test Plan:
- Reset, then read cmd addr=3 len=0 -> rsp_valid in cycle 3 after accept, rsp_data=0xFF, cmd_done 1 cycle after handshake.
- Write cmd addr=6 len=3, beats 0xA0,0xA1,0xA2,0xA3 -> memory addrs 6,7,0,1 written; then read addr=6 len=3 -> 0xA0,0xA1,0xA2,0xA3 in order; addr 2 still reads 0xFF.
- Write burst with wdat_valid toggling 1,0,0,1,... -> mem_enable only on valid cycles, addresses contiguous, cmd_done after 4th beat only.
- Read len=7 with rsp_ready low for 5 cycles on beat 2 -> rsp_valid/rsp_data stable throughout the stall, no extra mem_enable pulses, all 8 values correct.
- Assert rst mid write burst (after 2 of 4 beats) -> outputs drop immediately, cmd_ready=1 after release, no cmd_done; readback of all addresses = 0xFF.
- cmd_valid held high with a second command queued -> accepted in the cmd_done cycle, no idle gap.
